// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - RAW interlock, redirect flush and stall watchdog for the 5-stage pipe
module pipe_hazard_ctrl #(
    parameter bit WB_BYPASS = 1'b0,
    parameter int MAX_STALL = 8,
    parameter int CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_valid_i,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic             id_use_rs_i,
    input  logic             id_use_rt_i,
    input  logic             id_regwrite_i,
    input  logic [4:0]       id_rd_i,
    input  logic             redirect_i,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic             ex_mem_flush_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             deadlock_o
);

    // Wide enough to hold MAX_STALL itself; the run counter parks there.
    localparam int RS_W = $clog2(MAX_STALL + 1);

    logic            ex_v, mem_v, wb_v;
    logic [4:0]      ex_rd, mem_rd, wb_rd;
    logic [RS_W-1:0] run_stall;
    logic [RS_W-1:0] run_stall_nxt;
    logic            wv;
    logic            hit_rs, hit_rt;
    logic            haz;

    // The WB slot only matters when the register file cannot serve a same-cycle write to ID.
    assign hit_rs = (ex_v  && ex_rd  == id_rs_i) ||
                    (mem_v && mem_rd == id_rs_i) ||
                    (!WB_BYPASS && wb_v && wb_rd == id_rs_i);
    assign hit_rt = (ex_v  && ex_rd  == id_rt_i) ||
                    (mem_v && mem_rd == id_rt_i) ||
                    (!WB_BYPASS && wb_v && wb_rd == id_rt_i);

    // $0 is hard-wired, so it is neither a source of hazards nor worth tracking.
    assign wv  = id_valid_i & id_regwrite_i & (id_rd_i != 5'd0);
    assign haz = id_valid_i & ~redirect_i &
                 ((id_use_rs_i & (id_rs_i != 5'd0) & hit_rs) |
                  (id_use_rt_i & (id_rt_i != 5'd0) & hit_rt));

    assign run_stall_nxt = (run_stall == RS_W'(MAX_STALL)) ? run_stall : run_stall + RS_W'(1);

    // Pipeline register controls: reset holds everything, then redirect > stall > run.
    always_comb begin
        pc_write_o     = 1'b1;
        if_id_write_o  = 1'b1;
        if_id_flush_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        ex_mem_flush_o = 1'b0;
        if (rst_i) begin
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            if_id_flush_o  = 1'b1;
            id_ex_flush_o  = 1'b1;
            ex_mem_flush_o = 1'b1;
        end else if (redirect_i) begin
            if_id_flush_o  = 1'b1;
            id_ex_flush_o  = 1'b1;
            ex_mem_flush_o = 1'b1;
        end else if (haz) begin
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            id_ex_flush_o  = 1'b1;
        end
    end

    // Shadow scoreboard of in-flight destinations, advancing in lockstep with the pipe.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_v   <= 1'b0;
            mem_v  <= 1'b0;
            wb_v   <= 1'b0;
            ex_rd  <= 5'd0;
            mem_rd <= 5'd0;
            wb_rd  <= 5'd0;
        end else if (redirect_i) begin
            // The MEM instruction commits; the younger two are squashed.
            ex_v  <= 1'b0;
            mem_v <= 1'b0;
            wb_v  <= mem_v;
            wb_rd <= mem_rd;
        end else if (haz) begin
            // A bubble enters EX while older work keeps draining.
            ex_v   <= 1'b0;
            mem_v  <= ex_v;
            mem_rd <= ex_rd;
            wb_v   <= mem_v;
            wb_rd  <= mem_rd;
        end else begin
            ex_v   <= wv;
            ex_rd  <= id_rd_i;
            mem_v  <= ex_v;
            mem_rd <= ex_rd;
            wb_v   <= mem_v;
            wb_rd  <= mem_rd;
        end
    end

    // Saturating statistics, consecutive-stall run length and sticky deadlock flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
            run_stall   <= '0;
            deadlock_o  <= 1'b0;
        end else begin
            if (haz && stall_cnt_o != {CNT_W{1'b1}})
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            if (redirect_i && flush_cnt_o != {CNT_W{1'b1}})
                flush_cnt_o <= flush_cnt_o + CNT_W'(1);
            if (haz) begin
                run_stall <= run_stall_nxt;
                if (run_stall_nxt == RS_W'(MAX_STALL))
                    deadlock_o <= 1'b1;
            end else begin
                run_stall <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       rw;
        logic [4:0] rd;
    } ins_t;

    typedef struct {
        string      tag;
        logic [4:0] c0;
        logic [4:0] c1;
    } exp_t;

    // {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush}
    localparam logic [4:0] RUN = 5'b11000;
    localparam logic [4:0] STL = 5'b00010;
    localparam logic [4:0] RED = 5'b11111;
    localparam logic [4:0] RST = 5'b00111;

    localparam ins_t NOP   = '{v:1'b0, rs:5'd0, rt:5'd0, urs:1'b0, urt:1'b0, rw:1'b0, rd:5'd0};
    localparam ins_t ADD1  = '{v:1'b1, rs:5'd2, rt:5'd3, urs:1'b1, urt:1'b1, rw:1'b1, rd:5'd1};
    localparam ins_t ADD4  = '{v:1'b1, rs:5'd5, rt:5'd6, urs:1'b1, urt:1'b1, rw:1'b1, rd:5'd4};
    localparam ins_t SUB2  = '{v:1'b1, rs:5'd1, rt:5'd3, urs:1'b1, urt:1'b1, rw:1'b1, rd:5'd2};
    localparam ins_t ADDI0 = '{v:1'b1, rs:5'd0, rt:5'd0, urs:1'b1, urt:1'b0, rw:1'b1, rd:5'd0};
    localparam ins_t ADD00 = '{v:1'b1, rs:5'd0, rt:5'd0, urs:1'b1, urt:1'b1, rw:1'b1, rd:5'd2};

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    ins_t cur = NOP;
    logic redirect = 1'b0;

    logic        pw0, iw0, iff0, ief0, emf0, dl0;
    logic        pw1, iw1, iff1, ief1, emf1, dl1;
    logic        pw2, iw2, iff2, ief2, emf2, dl2;
    logic [15:0] sc0, fc0, sc1, fc1, sc2, fc2;
    logic [4:0]  ctl0, ctl1, ctl2;

    int total = 0;
    int bad = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    assign ctl0 = {pw0, iw0, iff0, ief0, emf0};
    assign ctl1 = {pw1, iw1, iff1, ief1, emf1};
    assign ctl2 = {pw2, iw2, iff2, ief2, emf2};

    pipe_hazard_ctrl #(.WB_BYPASS(1'b0), .MAX_STALL(8), .CNT_W(16)) dut0 (
        .clk_i(clk), .rst_i(rst_i), .id_valid_i(cur.v), .id_rs_i(cur.rs), .id_rt_i(cur.rt),
        .id_use_rs_i(cur.urs), .id_use_rt_i(cur.urt), .id_regwrite_i(cur.rw), .id_rd_i(cur.rd),
        .redirect_i(redirect), .pc_write_o(pw0), .if_id_write_o(iw0), .if_id_flush_o(iff0),
        .id_ex_flush_o(ief0), .ex_mem_flush_o(emf0), .stall_cnt_o(sc0), .flush_cnt_o(fc0),
        .deadlock_o(dl0));

    pipe_hazard_ctrl #(.WB_BYPASS(1'b1), .MAX_STALL(8), .CNT_W(16)) dut1 (
        .clk_i(clk), .rst_i(rst_i), .id_valid_i(cur.v), .id_rs_i(cur.rs), .id_rt_i(cur.rt),
        .id_use_rs_i(cur.urs), .id_use_rt_i(cur.urt), .id_regwrite_i(cur.rw), .id_rd_i(cur.rd),
        .redirect_i(redirect), .pc_write_o(pw1), .if_id_write_o(iw1), .if_id_flush_o(iff1),
        .id_ex_flush_o(ief1), .ex_mem_flush_o(emf1), .stall_cnt_o(sc1), .flush_cnt_o(fc1),
        .deadlock_o(dl1));

    pipe_hazard_ctrl #(.WB_BYPASS(1'b0), .MAX_STALL(3), .CNT_W(16)) dut2 (
        .clk_i(clk), .rst_i(rst_i), .id_valid_i(cur.v), .id_rs_i(cur.rs), .id_rt_i(cur.rt),
        .id_use_rs_i(cur.urs), .id_use_rt_i(cur.urt), .id_regwrite_i(cur.rw), .id_rd_i(cur.rd),
        .redirect_i(redirect), .pc_write_o(pw2), .if_id_write_o(iw2), .if_id_flush_o(iff2),
        .id_ex_flush_o(ief2), .ex_mem_flush_o(emf2), .stall_cnt_o(sc2), .flush_cnt_o(fc2),
        .deadlock_o(dl2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One ID cycle: drive at the falling edge, queue the expectation, compare mid low phase.
    task automatic step(input string tag, input ins_t i, input logic redir,
                        input logic [4:0] c0, input logic [4:0] c1);
        exp_t e;
        @(negedge clk);
        cur = i;
        redirect = redir;
        e.tag = tag;
        e.c0 = c0;
        e.c1 = c1;
        q.push_back(e);
        #2;
        e = q.pop_front();
        chk({e.tag, "/ctl0"}, 32'(ctl0), 32'(e.c0));
        chk({e.tag, "/ctl1"}, 32'(ctl1), 32'(e.c1));
        chk({e.tag, "/ctl2"}, 32'(ctl2), 32'(e.c0));
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        #2;
        chk("rst/ctl0", 32'(ctl0), 32'(RST));
        chk("rst/ctl1", 32'(ctl1), 32'(RST));
        chk("rst/sc0", 32'(sc0), 0);
        chk("rst/fc0", 32'(fc0), 0);
        chk("rst/dl2", 32'(dl2), 0);
        @(negedge clk);
        rst_i = 1'b0;

        // Hazard-free pair
        step("first", NOP, 1'b0, RUN, RUN);
        step("hf_add1", ADD1, 1'b0, RUN, RUN);
        step("hf_add4", ADD4, 1'b0, RUN, RUN);
        for (int k = 0; k < 3; k++) step("hf_nop", NOP, 1'b0, RUN, RUN);
        chk("hf/sc0", 32'(sc0), 0);
        chk("hf/sc1", 32'(sc1), 0);

        // Back-to-back RAW: 3 stalls without bypass, 2 with
        step("b2b_add1", ADD1, 1'b0, RUN, RUN);
        step("b2b_s1", SUB2, 1'b0, STL, STL);
        step("b2b_s2", SUB2, 1'b0, STL, STL);
        step("b2b_s3", SUB2, 1'b0, STL, RUN);
        chk("b2b/dl2_before", 32'(dl2), 0);
        step("b2b_go", SUB2, 1'b0, RUN, RUN);
        chk("b2b/dl2_after", 32'(dl2), 1);
        chk("b2b/dl0", 32'(dl0), 0);
        chk("b2b/sc0", 32'(sc0), 3);
        chk("b2b/sc1", 32'(sc1), 2);
        for (int k = 0; k < 3; k++) step("b2b_nop", NOP, 1'b0, RUN, RUN);

        // One independent instruction between producer and consumer
        step("gap_add1", ADD1, 1'b0, RUN, RUN);
        step("gap_add4", ADD4, 1'b0, RUN, RUN);
        step("gap_s1", SUB2, 1'b0, STL, STL);
        step("gap_s2", SUB2, 1'b0, STL, RUN);
        step("gap_go", SUB2, 1'b0, RUN, RUN);
        chk("gap/sc0", 32'(sc0), 5);
        chk("gap/sc1", 32'(sc1), 3);
        for (int k = 0; k < 3; k++) step("gap_nop", NOP, 1'b0, RUN, RUN);

        // $0 is never a hazard
        step("z_addi0", ADDI0, 1'b0, RUN, RUN);
        step("z_add00", ADD00, 1'b0, RUN, RUN);
        for (int k = 0; k < 3; k++) step("z_nop", NOP, 1'b0, RUN, RUN);
        chk("z/sc0", 32'(sc0), 5);

        // Redirect in the second stall cycle
        step("rd_add1", ADD1, 1'b0, RUN, RUN);
        step("rd_s1", SUB2, 1'b0, STL, STL);
        step("rd_redir", SUB2, 1'b1, RED, RED);
        step("rd_after", SUB2, 1'b0, STL, RUN);
        chk("rd/fc0", 32'(fc0), 1);
        chk("rd/fc1", 32'(fc1), 1);
        chk("rd/sc0", 32'(sc0), 6);
        chk("rd/sc1", 32'(sc1), 4);
        step("rd_go", SUB2, 1'b0, RUN, RUN);
        chk("rd/sc0_go", 32'(sc0), 7);

        // Back-to-back redirects each count once
        step("rr_1", NOP, 1'b1, RED, RED);
        step("rr_2", NOP, 1'b1, RED, RED);
        step("rr_nop", NOP, 1'b0, RUN, RUN);
        chk("rr/fc0", 32'(fc0), 3);
        chk("rr/fc2", 32'(fc2), 3);
        chk("rr/sc1", 32'(sc1), 4);
        chk("rr/dl2_sticky", 32'(dl2), 1);
        chk("rr/dl1", 32'(dl1), 0);
        for (int k = 0; k < 2; k++) step("rr_drain", NOP, 1'b0, RUN, RUN);

        // Asynchronous reset between clock edges, mid-stall
        step("ar_add1", ADD1, 1'b0, RUN, RUN);
        step("ar_s1", SUB2, 1'b0, STL, STL);
        #1 rst_i = 1'b1;
        #1;
        chk("ar/ctl0", 32'(ctl0), 32'(RST));
        chk("ar/ctl1", 32'(ctl1), 32'(RST));
        chk("ar/sc0", 32'(sc0), 0);
        chk("ar/fc0", 32'(fc0), 0);
        chk("ar/dl2", 32'(dl2), 0);
        cur = NOP;
        @(negedge clk);
        rst_i = 1'b0;
        step("ar_first", NOP, 1'b0, RUN, RUN);
        step("ar_sub", SUB2, 1'b0, RUN, RUN);
        chk("ar/sc0_after", 32'(sc0), 0);
        chk("ar/sc1_after", 32'(sc1), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
